// File: rtl/cache_pkg.sv
// Shared cache geometry, refill FSM state encoding and line storage type.
package cache_pkg;

  localparam int LINE_WORDS  = 4;
  localparam int OFFSET_BITS = 4;
  localparam int SET_BITS    = 2;
  localparam int TAG_BITS    = 26;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2,
    FILL  = 2'd3
  } refill_state_t;

  typedef logic [LINE_WORDS-1:0][31:0] line_t;

endpackage

// File: rtl/cache_refill_ctrl.sv
// Line refill controller: four pipelined word reads, assemble, one-cycle fill strobe.
// Optional macro CRITICAL_WORD_FIRST_EN starts the read burst at the missing word.
module cache_refill_ctrl
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_req,
  input  logic [ADDR_WIDTH-1:0] miss_addr,
  output logic                  stall,
  output logic                  busy,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  fill_valid,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic [DATA_WIDTH-1:0] fill_d0,
  output logic [DATA_WIDTH-1:0] fill_d1,
  output logic [DATA_WIDTH-1:0] fill_d2,
  output logic [DATA_WIDTH-1:0] fill_d3
);

  refill_state_t state, state_nx;
  logic [ADDR_WIDTH-OFFSET_BITS-1:0] base_q, base_nx;
  logic [1:0] issue_cnt, issue_cnt_nx;
  logic [1:0] widx, widx_nx;
  logic [1:0] cap_idx;
  logic       cap_en;
  logic [1:0] start_idx;
  logic       rd_nx, fill_nx;
  logic [DATA_WIDTH-1:0] words [LINE_WORDS];
  logic unused_addr_bits;

  assign unused_addr_bits = ^miss_addr[OFFSET_BITS-1:0];

`ifdef CRITICAL_WORD_FIRST_EN
  assign start_idx = miss_addr[3:2];
`else
  assign start_idx = 2'd0;
`endif

  always_comb begin
    state_nx     = state;
    base_nx      = base_q;
    issue_cnt_nx = issue_cnt;
    widx_nx      = widx;
    case (state)
      IDLE: begin
        if (miss_req) begin
          state_nx     = REQ;
          base_nx      = miss_addr[ADDR_WIDTH-1:OFFSET_BITS];
          issue_cnt_nx = 2'd0;
          widx_nx      = start_idx;
        end
      end
      REQ: begin
        // 2-bit word index wraps inside the line, so no carry into the base
        issue_cnt_nx = issue_cnt + 2'd1;
        widx_nx      = widx + 2'd1;
        if (issue_cnt == 2'd3) state_nx = DRAIN;
      end
      DRAIN:   state_nx = FILL;
      FILL:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    rd_nx   = (state_nx == REQ);
    fill_nx = (state_nx == FILL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      base_q     <= '0;
      issue_cnt  <= 2'd0;
      widx       <= 2'd0;
      cap_idx    <= 2'd0;
      cap_en     <= 1'b0;
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      fill_valid <= 1'b0;
      fill_addr  <= '0;
      for (int i = 0; i < LINE_WORDS; i++) words[i] <= '0;
    end else begin
      state      <= state_nx;
      base_q     <= base_nx;
      issue_cnt  <= issue_cnt_nx;
      widx       <= widx_nx;
      mem_rd_en  <= rd_nx;
      if (rd_nx) mem_addr <= {base_nx, widx_nx, 2'b00};
      // Read data returns one cycle later; remember which slot it belongs to
      cap_en     <= mem_rd_en;
      cap_idx    <= widx;
      if (cap_en) words[cap_idx] <= mem_rdata;
      fill_valid <= fill_nx;
      if (fill_nx) fill_addr <= {base_q, {OFFSET_BITS{1'b0}}};
    end
  end

  assign busy    = (state != IDLE);
  assign stall   = miss_req | busy;
  assign fill_d0 = words[0];
  assign fill_d1 = words[1];
  assign fill_d2 = words[2];
  assign fill_d3 = words[3];

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl with a read/fill scoreboard and memory model.
module tb_cache_refill_ctrl;

  logic        clk, rst, miss_req;
  logic [31:0] miss_addr;
  logic        stall, busy, mem_rd_en, fill_valid;
  logic [31:0] mem_addr, mem_rdata, fill_addr;
  logic [31:0] fill_d0, fill_d1, fill_d2, fill_d3;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t;

  logic [31:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [31:0] fill_q[$];
  int          fill_cyc_q[$];

  cache_refill_ctrl dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
    .stall(stall), .busy(busy), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .fill_valid(fill_valid), .fill_addr(fill_addr),
    .fill_d0(fill_d0), .fill_d1(fill_d1), .fill_d2(fill_d2), .fill_d3(fill_d3)
  );

  // clock / cycle counter / memory model
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial mem_rdata = '0;
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem_addr ^ 32'hA5A5_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // expectations for a miss accepted in IDLE at cycle tm
  task automatic push_exp(input logic [31:0] addr, input int tm, input int n_reads, input bit with_fill);
    logic [31:0] base;
    logic [1:0]  c, idx;
    base = addr & 32'hFFFF_FFF0;
`ifdef CRITICAL_WORD_FIRST_EN
    c = addr[3:2];
`else
    c = 2'd0;
`endif
    for (int i = 0; i < n_reads; i++) begin
      idx = c + 2'(i);
      exp_q.push_back(base | {28'd0, idx, 2'b00});
      exp_cyc_q.push_back(tm + 1 + i);
    end
    if (with_fill) begin
      fill_q.push_back(base);
      for (int k = 0; k < 4; k++) fill_q.push_back((base + 32'(4 * k)) ^ 32'hA5A5_0000);
      fill_cyc_q.push_back(tm + 6);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
      chk("missing_read", 32'(cyc), 32'(exp_cyc_q[0]));
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
    end
    if (fill_cyc_q.size() > 0 && fill_cyc_q[0] < cyc) begin
      chk("missing_fill", 32'(cyc), 32'(fill_cyc_q[0]));
      void'(fill_cyc_q.pop_front());
      repeat (5) void'(fill_q.pop_front());
    end
    if (mem_rd_en) begin
      if (exp_q.size() == 0) chk("unexpected_read", {31'd0, mem_rd_en}, 32'd0);
      else begin
        chk("rd_addr", mem_addr, exp_q.pop_front());
        chk("rd_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
      end
    end
    if (fill_valid) begin
      if (fill_cyc_q.size() == 0) chk("unexpected_fill", {31'd0, fill_valid}, 32'd0);
      else begin
        chk("fill_cycle", 32'(cyc), 32'(fill_cyc_q.pop_front()));
        chk("fill_addr", fill_addr, fill_q.pop_front());
        chk("fill_d0", fill_d0, fill_q.pop_front());
        chk("fill_d1", fill_d1, fill_q.pop_front());
        chk("fill_d2", fill_d2, fill_q.pop_front());
        chk("fill_d3", fill_d3, fill_q.pop_front());
      end
    end
  end

  task automatic single_miss(input logic [31:0] addr);
    @(negedge clk);
    t = cyc;
    push_exp(addr, t, 4, 1'b1);
    miss_req  = 1'b1;
    miss_addr = addr;
    @(negedge clk);
    miss_req = 1'b0;
    repeat (7) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; miss_req = 1'b0; miss_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_fill_valid", {31'd0, fill_valid}, 32'd0);
    chk("rst_fill_addr", fill_addr, 32'd0);
    chk("rst_fill_d0", fill_d0, 32'd0);
    chk("rst_fill_d3", fill_d3, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;

    // basic refill with stall/busy window
    @(negedge clk);
    t = cyc;
    push_exp(32'h0000_0124, t, 4, 1'b1);
    miss_req = 1'b1; miss_addr = 32'h0000_0124;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("stall_k%0d", k), {31'd0, stall}, {31'd0, k <= 6});
      chk($sformatf("busy_k%0d", k), {31'd0, busy}, {31'd0, k >= 1 && k <= 6});
      @(negedge clk);
      miss_req = 1'b0;
    end

    // top of memory, no carry out of the line
    single_miss(32'hFFFF_FFFC);

    // held request: changes during refill ignored, re-miss right after FILL
    @(negedge clk);
    t = cyc;
    push_exp(32'h0000_0124, t, 4, 1'b1);
    push_exp(32'h0000_0200, t + 7, 4, 1'b1);
    miss_req = 1'b1; miss_addr = 32'h0000_0124;
    repeat (2) @(negedge clk);
    miss_addr = 32'h0000_0200;
    repeat (5) @(negedge clk);
    chk("held_busy_t7", {31'd0, busy}, 32'd0);
    chk("held_stall_t7", {31'd0, stall}, 32'd1);
    @(negedge clk);
    miss_req = 1'b0;
    repeat (8) @(negedge clk);

    // reset in the middle of REQ
    @(negedge clk);
    t = cyc;
    push_exp(32'h0000_0300, t, 3, 1'b0);
    miss_req = 1'b1; miss_addr = 32'h0000_0300;
    @(negedge clk);
    miss_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("midrst_fill_valid", {31'd0, fill_valid}, 32'd0);
    chk("midrst_fill_d0", fill_d0, 32'd0);
    chk("midrst_fill_d1", fill_d1, 32'd0);
    chk("midrst_fill_d2", fill_d2, 32'd0);
    chk("midrst_fill_d3", fill_d3, 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    // reset and miss together: reset wins
    rst = 1'b1; miss_req = 1'b1; miss_addr = 32'h0000_0400;
    @(negedge clk);
    rst = 1'b0; miss_req = 1'b0;
    chk("rst_miss_busy", {31'd0, busy}, 32'd0);
    chk("rst_miss_rd_en", {31'd0, mem_rd_en}, 32'd0);
    repeat (3) @(negedge clk);

    // non-zero word offset (critical word first when enabled)
    single_miss(32'h0000_0128);

    // back-to-back misses, each in the first IDLE cycle
    @(negedge clk);
    t = cyc;
    push_exp(32'h0000_0040, t, 4, 1'b1);
    push_exp(32'h0000_0080, t + 7, 4, 1'b1);
    miss_req = 1'b1; miss_addr = 32'h0000_0040;
    @(negedge clk);
    miss_req = 1'b0;
    repeat (6) @(negedge clk);
    miss_req = 1'b1; miss_addr = 32'h0000_0080;
    @(negedge clk);
    miss_req = 1'b0;

    for (int w = 0; w < 40 && (exp_q.size() > 0 || fill_cyc_q.size() > 0); w++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("reads_drained", 32'(exp_q.size()), 32'd0);
    chk("fills_drained", 32'(fill_cyc_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
- Memory-side refill controller for the 4-set direct-mapped data cache (16-byte lines, 4 x 32-bit words).
- On a cache miss it reads the whole line from data memory: four sequential word reads with 1-cycle read latency.
- It assembles the four words and presents them as d0..d3 with a one-cycle fill strobe.
- It holds the pipeline stall high for the whole refill.

Parameters:
- DATA_WIDTH, 32, word width of memory data and fill words
- ADDR_WIDTH, 32, byte-address width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- miss_req  in  1  cache reports miss for miss_addr (level, sampled in IDLE only)
- miss_addr  in  ADDR_WIDTH  byte address of the missing access
- stall  out  1  pipeline stall; combinational: miss_req OR (state != IDLE)
- busy  out  1  registered: state != IDLE
- mem_rd_en  out  1  data-memory read strobe
- mem_addr  out  ADDR_WIDTH  word-aligned read address (bits [1:0] = 0)
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after mem_rd_en
- fill_valid  out  1  one-cycle pulse: line assembled, cache must write it
- fill_addr  out  ADDR_WIDTH  line base address {miss_addr[31:4],4'b0} of the fill
- fill_d0..fill_d3  out  DATA_WIDTH each  words at line offsets 0x0,0x4,0x8,0xC

Behaviour:
- Reset values (applied on the same edge when rst=1):
  - state = IDLE.
  - Outputs 0: mem_rd_en, mem_addr, fill_valid, fill_addr, fill_d0..3, busy.
  - Internal counters = 0.
- FSM states: IDLE, REQ, DRAIN, FILL.
- IDLE:
  - If miss_req=1: latch line base = {miss_addr[ADDR_WIDTH-1:4],4'b0}, set issue counter = 0, go to REQ.
  - Otherwise stay in IDLE.
- REQ, four cycles:
  - mem_rd_en=1 each cycle.
  - mem_addr = base + 4*widx, with widx = issue counter (2-bit).
  - Counter increments each cycle; after widx=3 go to DRAIN.
- Capture: in every cycle following a mem_rd_en cycle, mem_rdata is written into word slot widx of the previous issue (pipelined index register).
- DRAIN:
  - mem_rd_en=0.
  - Captures the last word, then go to FILL.
- FILL:
  - fill_valid=1 for exactly one cycle; fill_addr = base; fill_d0..3 stable.
  - Go to IDLE.
- Timing for miss_req seen in IDLE at cycle t:
  - Reads are issued in cycles t+1..t+4.
  - fill_valid is high in cycle t+6.
  - busy is high from t+1 to t+6.
  - stall is high from t to t+6.
- Word data:
  - fill_d0..3 hold their value after FILL until the next capture; they are not cleared.
  - The cache reads them only while fill_valid=1.
- Boundary conditions:
  - miss_req while not IDLE: ignored, no queueing.
  - miss_req still high in the cycle after FILL (IDLE again): treated as a new miss. The cache must drop miss_req once it reports a hit.
  - Address wrap: the counter is 2 bits, so reads never leave the 16-byte line; base 0xFFFF_FFF0 reads 0xFFFF_FFF0..0xFFFF_FFFC with no carry out.
  - miss_addr bits [3:0] never affect the addresses issued in default mode.
  - rst during REQ, DRAIN or FILL: next state IDLE; no fill_valid pulse; mem_rd_en=0 on the next cycle; partially captured words are discarded (cleared).
  - rst and miss_req in the same cycle: reset wins.

Optional Feature:
- Macro: CRITICAL_WORD_FIRST_EN.
- Defined:
  - Issue order starts at c = miss_addr[3:2] and wraps mod 4. Example: c=2 gives offsets 0x8, 0xC, 0x0, 0x4.
  - Each word still lands in fill_d[offset index].
  - Latency and fill timing are unchanged.
- Undefined: issue order is always 0, 1, 2, 3.

Decomposition:
- Shared package cache_pkg holds:
  - LINE_WORDS=4, OFFSET_BITS=4, SET_BITS=2, TAG_BITS=26
  - typedef enum refill_state_t {IDLE, REQ, DRAIN, FILL}
  - typedef line_t (array of 4 words)
- Sub-module: none. The 2-bit issue counter and capture index stay inline; the block is a single FSM plus datapath.

Test Plan:
- Basic refill:
  - Stimulus: memory word at addr X holds X^0xA5A5_0000; pulse miss_req with miss_addr=0x0000_0124.
  - Response: mem_addr 0x120, 0x124, 0x128, 0x12C in cycles t+1..t+4; fill_valid only at t+6; fill_addr=0x120; fill_d0..3 = 0xA5A5_0120, 0xA5A5_0124, 0xA5A5_0128, 0xA5A5_012C; stall high t..t+6.
- Top-of-memory wrap:
  - Stimulus: miss_addr=0xFFFF_FFFC.
  - Response: reads 0xFFFF_FFF0..0xFFFF_FFFC; no address ever below 0xFFFF_FFF0.
- Ignored request:
  - Stimulus: hold miss_req high through the refill, with miss_addr changed to 0x200 mid-REQ.
  - Response: first fill uses base 0x120; a second refill of 0x200 starts in the cycle after FILL.
- Reset mid-operation:
  - Stimulus: assert rst in t+3.
  - Response: state IDLE at t+4; mem_rd_en=0 and busy=0 at t+4; no fill_valid; fill_d0..3 = 0.
- Critical word first (CRITICAL_WORD_FIRST_EN defined):
  - Stimulus: miss_addr=0x0000_0128.
  - Response: mem_addr sequence 0x128, 0x12C, 0x120, 0x124; fill_d0..3 identical to the basic refill case.
- Back-to-back misses:
  - Stimulus: two misses (0x040 then 0x080), each asserted in the first IDLE cycle.
  - Response: fill_valid pulses exactly 7 cycles apart with the correct line data.
